click_bcd_counter: RTL
======================

Name: click_bcd_counter

Overview:
- Debounces raw push-button inputs and counts confirmed single clicks as a 4-digit packed BCD value.
- Output num_out[15:0] drives the 4-digit seven-segment scanner directly. Digit 0 is in bits [3:0]; each nibble is always 0-9.
- Sits between the board keys and the display stage. Runs in the 25 MHz system domain.

Parameters:
- DB_CYCLES, 250000, consecutive stable cycles needed to confirm a press or release (10 ms at 25 MHz); minimum 2.
- DB_W, 18, width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  input  1  system clock, 25 MHz
- rst_n  input  1  asynchronous active-low reset
- key_inc_n  input  1  raw increment button, active-low, asynchronous to clk
- key_clr_n  input  1  raw clear button, active-low, asynchronous to clk
- num_out  output  16  packed BCD count {d3,d2,d1,d0}, registered
- click_pulse  output  1  one-cycle strobe on each confirmed increment click

Behaviour:
- Clocking/reset: single clock clk; reset asynchronous, active-low on rst_n. All flops clear on rst_n low.
- Reset values: num_out=16'h0000, click_pulse=0. Synchronizer flops =1 (released). Debounce FSMs in IDLE with counter 0.
- Synchronizer: each raw key passes through 2 flops; a "pressed" level is sync output = 0.
- Debounce FSM, one independent instance per key, with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: synced pressed -> PRESS_WAIT, counter=0.
  - PRESS_WAIT: still pressed -> counter+1. Counter reaches DB_CYCLES-1 -> HELD and assert confirm for exactly 1 cycle. Released at any point -> IDLE, counter=0.
  - HELD: synced released -> RELEASE_WAIT, counter=0. A held key never re-confirms (no auto-repeat).
  - RELEASE_WAIT: still released -> counter+1. Counter reaches DB_CYCLES-1 -> IDLE. Pressed again -> HELD, counter=0, no new confirm.
- Latency: from the first clk edge sampling a stable low raw key to click_pulse high = 2 (sync) + DB_CYCLES cycles.
- Counting:
  - On inc confirm: num_out increments in BCD and click_pulse=1, both on the same edge.
  - Per digit: 9 -> 0 with carry into the next digit.
  - 9999 -> 0000, wraps silently.
- Clear: on clr confirm, num_out=0000 on the next edge.
- Clear and inc confirm in the same cycle: clear wins, num_out=0000. click_pulse still asserts, since the click was detected.
- Glitches shorter than DB_CYCLES never change num_out.
- Reset mid-operation: everything returns to reset values immediately; a key still held at reset release must be debounced again and counts once.
- num_out holds its value between events. It never contains a nibble >9.

Optional Feature:
- Macro DOWN_KEY_EN.
- Defined:
  - Adds input port key_dec_n (1 bit, active-low), with its own synchronizer and debounce FSM.
  - A dec confirm decrements in BCD: 0 -> 9 with borrow; 0000 wraps to 9999.
  - Same-cycle inc and dec confirms cancel: num_out unchanged, click_pulse=1.
  - Clear still has top priority.
  - click_pulse asserts for inc confirms only.
- Undefined: no key_dec_n port and no decrement logic; behaviour exactly as above.

Test Plan (bench uses DB_CYCLES=4):
- Reset asserted mid-count with num_out=0042 -> num_out=0000 and click_pulse=0 immediately, asynchronously.
- key_inc_n low for 10 cycles then high -> exactly one click_pulse, 6 cycles after first low sample; num_out 0000->0001.
- key_inc_n low for 3 cycles (glitch), then bouncing 1-cycle toggles -> no click_pulse, num_out unchanged.
- Preload by 9999 clicks (or 0099 and 0999 checks) -> one click gives 0100 and 1000; one click from 9999 gives 0000.
- key_clr_n and key_inc_n pressed simultaneously from num_out=0057 -> num_out=0000, one click_pulse.
- With DOWN_KEY_EN: from 0000 one dec click -> 9999. From 0010 one dec click -> 0009. Simultaneous inc and dec confirms -> unchanged.

Source files
------------

// File: rtl/click_bcd_counter.sv
// ---------------------------------------------------------------------------
// click_bcd_counter
//   Debounces raw push-button keys and counts confirmed single clicks as a
//   4-digit packed BCD value for the seven-segment scanner.
//
//   Optional feature macro: DOWN_KEY_EN (adds a decrement key).
//
//   Ports:
//     clk          system clock (25 MHz)
//     rst_n        asynchronous active-low reset
//     key_inc_n    raw increment key, active-low, asynchronous to clk
//     key_clr_n    raw clear key, active-low, asynchronous to clk
//     key_dec_n    raw decrement key, active-low (DOWN_KEY_EN only)
//     num_out      packed BCD count {d3,d2,d1,d0}, registered
//     click_pulse  one-cycle strobe per confirmed increment click
// ---------------------------------------------------------------------------

// Per-key synchronizer plus press/release debounce FSM.
//   clk, rst_n : clock / async active-low reset
//   key_n      : raw active-low key
//   confirm    : one-cycle strobe when a press is confirmed
module click_bcd_debounce #(
    parameter int DB_CYCLES = 250000,
    parameter int DB_W      = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic confirm
);
    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync;
    logic            pressed;
    logic [1:0]      state, state_nxt;
    logic [DB_W-1:0] cnt, cnt_nxt;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], key_n};
    end

    assign pressed = ~sync[1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        confirm   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pressed) begin
                    state_nxt = S_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!pressed) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HELD;
                    confirm   = 1'b1;
                end else begin
                    cnt_nxt = cnt + DB_W'(1);
                end
            end
            S_HELD: begin
                // No auto-repeat: only a debounced release re-arms.
                if (!pressed) begin
                    state_nxt = S_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin // S_RELEASE_WAIT
                if (pressed) begin
                    state_nxt = S_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + DB_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule

module click_bcd_counter #(
    parameter int DB_CYCLES = 250000,
    parameter int DB_W      = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_inc_n,
    input  logic        key_clr_n,
`ifdef DOWN_KEY_EN
    input  logic        key_dec_n,
`endif
    output logic [15:0] num_out,
    output logic        click_pulse
);
    localparam int KEY_INC = 0;
    localparam int KEY_CLR = 1;
`ifdef DOWN_KEY_EN
    localparam int NUM_KEYS = 3;
    localparam int KEY_DEC  = 2;
`else
    localparam int NUM_KEYS = 2;
`endif

    logic [NUM_KEYS-1:0] keys_n;
    logic [NUM_KEYS-1:0] confirm;
    logic                inc_cf, clr_cf, dec_cf;

`ifdef DOWN_KEY_EN
    assign keys_n = {key_dec_n, key_clr_n, key_inc_n};
    assign dec_cf = confirm[KEY_DEC];
`else
    assign keys_n = {key_clr_n, key_inc_n};
    assign dec_cf = 1'b0;
`endif
    assign inc_cf = confirm[KEY_INC];
    assign clr_cf = confirm[KEY_CLR];

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        click_bcd_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_n   (keys_n[k]),
            .confirm (confirm[k])
        );
    end

    // Ripple-carry BCD +1; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple-borrow BCD -1; 0000 wraps to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        logic [3:0]  d;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (b) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Clear dominates; simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_out     <= 16'h0000;
            click_pulse <= 1'b0;
        end else begin
            click_pulse <= inc_cf;
            if (clr_cf)
                num_out <= 16'h0000;
            else if (inc_cf && !dec_cf)
                num_out <= bcd_inc(num_out);
            else if (dec_cf && !inc_cf)
                num_out <= bcd_dec(num_out);
        end
    end
endmodule
